// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a SIZE x SIZE output-stationary systolic array.
// A job captures both operands, streams row i of A (delayed i steps) into the
// west edge and column j of B (delayed j steps) into the north edge, waits for
// the array to drain, then pulses done.
module systolic_feeder #(
  parameter int unsigned SIZE         = 4,
  parameter int unsigned DRAIN_CYCLES = 2 * SIZE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SIZE-1:0][SIZE-1:0][7:0] a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][7:0] b_mat,
  input  logic                           start,
  output logic                           ready,
  output logic [SIZE-1:0][7:0]           a_in,
  output logic [SIZE-1:0]                valid_a,
  output logic [SIZE-1:0][7:0]           b_in,
  output logic [SIZE-1:0]                valid_b,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned FeedLast  = 2 * SIZE - 2;
  localparam int unsigned DrainLast = DRAIN_CYCLES - 1;
  localparam int unsigned CntMax    = (FeedLast > DrainLast) ? FeedLast : DrainLast;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           accept;
  logic [SIZE-1:0][SIZE-1:0][7:0] a_q, a_d, b_q, b_d;
  logic [SIZE-1:0][7:0]           a_in_d, b_in_d;
  logic [SIZE-1:0]                valid_a_d, valid_b_d;
  logic [31:0]                    step;

  // Next-state and step counter; start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StFeed;
          cnt_d   = '0;
        end
      end
      StFeed: begin
        if (cnt_q == CntW'(FeedLast)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DrainLast)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Operands are sampled only on the accepting edge.
  always_comb begin
    a_d = accept ? a_mat : a_q;
    b_d = accept ? b_mat : b_q;
  end

  // Output values for the step the counter is about to hold, so the registered
  // outputs show step t during the (t+1)th cycle after acceptance.
  always_comb begin
    a_in_d    = '0;
    b_in_d    = '0;
    valid_a_d = '0;
    valid_b_d = '0;
    step      = 32'(cnt_d);
    if (state_d == StFeed) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          if (step == i + k) begin
            a_in_d[i]    = a_d[i][k];
            valid_a_d[i] = 1'b1;
            b_in_d[i]    = b_d[k][i];
            valid_b_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State, counter, captured operands and stream output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_in    <= '0;
      b_in    <= '0;
      valid_a <= '0;
      valid_b <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_in    <= a_in_d;
      b_in    <= b_in_d;
      valid_a <= valid_a_d;
      valid_b <= valid_b_d;
    end
  end

  // Status flags decode the registered state directly.
  always_comb begin
    ready = (state_q == StIdle);
    busy  = (state_q == StFeed) || (state_q == StDrain);
    done  = (state_q == StDone);
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int S = 4;
  localparam int D = 2 * S;
  localparam int L = 2 * S + D;  // cycle (counted from acceptance) that carries done

  logic                     clk = 1'b0;
  logic                     reset;
  logic [S-1:0][S-1:0][7:0] a_mat, b_mat;
  logic                     start;
  logic                     ready, busy, done;
  logic [S-1:0][7:0]        a_in, b_in;
  logic [S-1:0]             valid_a, valid_b;

  int checks = 0;
  int failures = 0;

  systolic_feeder #(.SIZE(S), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .a_mat(a_mat), .b_mat(b_mat), .start(start),
    .ready(ready), .a_in(a_in), .valid_a(valid_a), .b_in(b_in), .valid_b(valid_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job model: mc = cycles since acceptance (0 = idle).
  int       mc = 0;
  bit [7:0] ma[S][S];
  bit [7:0] mb[S][S];
  always @(posedge clk or posedge reset) begin
    if (reset) mc <= 0;
    else if (mc == 0) begin
      if (start) begin
        mc <= 1;
        for (int i = 0; i < S; i++)
          for (int k = 0; k < S; k++) begin
            ma[i][k] <= a_mat[i][k];
            mb[i][k] <= b_mat[i][k];
          end
      end
    end else if (mc == L) mc <= 0;
    else mc <= mc + 1;
  end

  // Ideal array fed by the DUT streams: PE(i,j) sees row i delayed j, column j delayed i.
  logic [S-1:0][7:0] ah[S], bh[S];
  logic [S-1:0]      av[S], bv[S];
  int                acc[S][S];
  int                final_out[S][S];
  int                cyc = 0;
  int                done_count = 0;

  // Per-cycle comparison against the model, plus the array accumulation.
  always @(negedge clk) begin
    logic [S-1:0][7:0] ea, eb;
    logic [S-1:0]      eva, evb;
    int t;
    cyc++;
    ea = '0; eb = '0; eva = '0; evb = '0;
    if (mc >= 1 && mc <= 2 * S - 1) begin
      t = mc - 1;
      for (int i = 0; i < S; i++)
        if (t >= i && t - i < S) begin
          ea[i] = ma[i][t-i]; eva[i] = 1'b1;
          eb[i] = mb[t-i][i]; evb[i] = 1'b1;
        end
    end
    check("ready", ready, mc == 0);
    check("busy", busy, mc >= 1 && mc <= L - 1);
    check("done", done, mc == L);
    check("a_in", a_in, ea);
    check("valid_a", valid_a, eva);
    check("b_in", b_in, eb);
    check("valid_b", valid_b, evb);
    if (done) done_count++;

    for (int d = S - 1; d > 0; d--) begin
      ah[d] = ah[d-1]; bh[d] = bh[d-1]; av[d] = av[d-1]; bv[d] = bv[d-1];
    end
    ah[0] = a_in; bh[0] = b_in; av[0] = valid_a; bv[0] = valid_b;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        if (mc == 0) acc[i][j] = 0;
        else if (av[j][i] && bv[i][j]) acc[i][j] += int'(ah[j][i]) * int'(bh[i][j]);
      end
    if (mc == L) final_out = acc;
  end

  task automatic start_job();
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int n = 0; n < 4 * L && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, seen, 1);
    @(negedge clk);
  endtask

  task automatic check_product(input string name);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        int e = 0;
        for (int k = 0; k < S; k++) e += int'(a_mat[i][k]) * int'(b_mat[k][j]);
        check(name, final_out[i][j], e);
      end
  endtask

  initial begin
    int va0_f, va0_l, va3_f, va3_l, busy_f, busy_l, busy_n, done_c, rdy_c, dc0, d1, d2;
    for (int d = 0; d < S; d++) begin ah[d] = '0; bh[d] = '0; av[d] = '0; bv[d] = '0; end
    reset = 1'b1; start = 1'b0; a_mat = '0; b_mat = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Latency and skew pattern.
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) begin
        a_mat[i][k] = 8'(16 * i + k);
        b_mat[i][k] = 8'(16 * i + k);
      end
    start_job();
    va0_f = 0; va0_l = 0; va3_f = 0; va3_l = 0; busy_f = 0; busy_l = 0; busy_n = 0;
    done_c = 0; rdy_c = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (valid_a[0]) begin if (va0_f == 0) va0_f = c; va0_l = c; end
      if (valid_a[3]) begin if (va3_f == 0) va3_f = c; va3_l = c; end
      if (busy) begin if (busy_f == 0) busy_f = c; busy_l = c; busy_n++; end
      if (done) done_c = c;
      if (ready && rdy_c == 0) rdy_c = c;
      if (c == 6) begin
        check("step5_a_in", a_in, 32'h3223_0000);
        check("step5_valid_a", valid_a, 4'b1100);
        check("step5_b_in", b_in, 32'h2332_0000);
        check("step5_valid_b", valid_b, 4'b1100);
      end
    end
    check("va0_first", va0_f, 1);
    check("va0_last", va0_l, 4);
    check("va3_first", va3_f, 4);
    check("va3_last", va3_l, 7);
    check("busy_first", busy_f, 1);
    check("busy_last", busy_l, 15);
    check("busy_count", busy_n, 15);
    check("done_cycle", done_c, 16);
    check("ready_again", rdy_c, 17);

    // End-to-end through the ideal array: identity times B[k][j] = k+j.
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) begin
        a_mat[i][k] = (i == k) ? 8'd1 : 8'd0;
        b_mat[i][k] = 8'(i + k);
      end
    start_job();
    wait_done("e2e_done");
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) check("e2e_out", final_out[i][j], i + j);

    // Start and operand changes during feed are ignored.
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) begin
        a_mat[i][k] = 8'(3 * i + k + 1);
        b_mat[i][k] = 8'(i + 2 * k);
      end
    dc0 = done_count;
    start_job();
    repeat (2) @(negedge clk);
    #1 start = 1'b1;
    a_mat = '1;
    repeat (8) @(negedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) a_mat[i][k] = 8'(3 * i + k + 1);
    wait_done("ign_done");
    check_product("ign_out");
    repeat (4) @(negedge clk);
    check("ign_single_done", done_count - dc0, 1);

    // Reset at step 3 abandons the job.
    start_job();
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_a_in", a_in, 0);
    check("abort_valid_a", valid_a, 0);
    check("abort_b_in", b_in, 0);
    check("abort_valid_b", valid_b, 0);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    dc0 = done_count;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (L + 4) @(negedge clk);
    check("abort_no_done", done_count - dc0, 0);
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) begin
        a_mat[i][k] = 8'(i + 2 * k + 1);
        b_mat[i][k] = 8'(3 * i + k);
      end
    start_job();
    wait_done("fresh_done");
    check_product("fresh_out");

    // Back-to-back with start held high.
    d1 = 0; d2 = 0;
    @(negedge clk); #1 start = 1'b1;
    for (int c = 0; c < 4 * L && d2 == 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    #1 start = 1'b0;
    check("b2b_second_done", d2 != 0, 1);
    check("b2b_gap", d2 - d1, 17);
    repeat (L + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
